// File: rtl/rc_filter_pkg.sv
// Shared types and constants for the RC filter bank.
// Latency: n/a (package only).
// Backpressure: n/a.
package rc_filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ALPHA_FRAC = 16;
  localparam int ALPHA_ONE  = 65536;
  localparam int ALPHA_W    = 17;

  // Discrete-time one-pole coefficient dt/(RC+dt) in 16-bit fraction; C is pre-scaled by 2^35.
  function automatic logic [ALPHA_W-1:0] alpha_default(input longint sample_rate,
                                                       input longint r,
                                                       input longint c35);
    longint per;
    longint num;
    longint den;
    per = (64'sd1 <<< 32) / sample_rate;
    num = per <<< ALPHA_FRAC;
    den = ((r * c35) >>> 3) + per;
    return ALPHA_W'(num / den);
  endfunction

endpackage

// File: rtl/rc_filter_mac.sv
// One-pole update y + floor(alpha*(x-y)/2^16), saturated to DATA_WIDTH.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller sequences one step per cycle.
module rc_filter_mac
  import rc_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y,
  input  logic        [ALPHA_W-1:0]    alpha,
  output logic signed [DATA_WIDTH-1:0] y_next
);

  localparam int PW = DATA_WIDTH + 1 + ALPHA_W + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       sum;

  always_comb begin
    diff = (DATA_WIDTH + 1)'(x) - (DATA_WIDTH + 1)'(y);
    prod = PW'(diff) * PW'($signed({1'b0, alpha}));
    sum  = PW'(y) + (prod >>> ALPHA_FRAC);
    if (sum > SAT_MAX) begin
      y_next = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      y_next = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      y_next = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rc_filter_bank.sv
// Multi-channel cascaded first-order RC low/high-pass filter, one shared MAC.
// Latency: CHANNELS*STAGES+2 cycles from accepted strobe to out_valid.
// Backpressure: none; strobes arriving while busy are dropped and flag overrun.
module rc_filter_bank
  import rc_filter_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int STAGES       = 1,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 47000,
  parameter int C_35_SHIFTED = 1615
) (
  input  logic                           clk,
  input  logic                           I_RSTn,
  input  logic                           audio_clk_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  input  logic                           coef_we,
  input  logic [2:0]                     coef_addr,
  input  logic [16:0]                    coef_data,
  input  logic [CHANNELS-1:0]            mode_hp,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           overrun
);

  localparam int NY = CHANNELS * STAGES;
  localparam logic [ALPHA_W-1:0] ALPHA_DEFAULT = alpha_default(SAMPLE_RATE, R, C_35_SHIFTED);

  state_t                        state_q, state_d;
  logic [2:0]                    ch_q, ch_d;
  logic [1:0]                    st_q, st_d;
  logic [CHANNELS-1:0]           mode_q, mode_d;
  logic [CHANNELS*DATA_WIDTH-1:0] out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic                          overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0]  x_q [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  x_d [CHANNELS];
  logic [ALPHA_W-1:0]            sh_q [CHANNELS];
  logic [ALPHA_W-1:0]            sh_d [CHANNELS];
  logic [ALPHA_W-1:0]            act_q [CHANNELS];
  logic [ALPHA_W-1:0]            act_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  y_q [NY];
  logic signed [DATA_WIDTH-1:0]  y_d [NY];

  logic signed [DATA_WIDTH-1:0]  mac_x, mac_y, mac_y_next;
  logic [ALPHA_W-1:0]            mac_alpha;
  logic [ALPHA_W-1:0]            coef_clamped;

  function automatic logic signed [DATA_WIDTH-1:0] hp_sat(input logic signed [DATA_WIDTH-1:0] a,
                                                          input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH:0] d;
    d = (DATA_WIDTH + 1)'(a) - (DATA_WIDTH + 1)'(b);
    if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
      return d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return d[DATA_WIDTH-1:0];
  endfunction

  assign coef_clamped = (coef_data > 17'(ALPHA_ONE)) ? 17'(ALPHA_ONE) : coef_data;

  // Stage 0 filters the captured sample; later stages filter the stage just updated.
  always_comb begin
    mac_x     = '0;
    mac_y     = '0;
    mac_alpha = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == 3'(c)) begin
        mac_alpha = act_q[c];
        mac_x     = x_q[c];
        for (int s = 0; s < STAGES; s++) begin
          if (st_q == 2'(s)) begin
            mac_y = y_q[c*STAGES + s];
            if (s > 0) mac_x = y_q[c*STAGES + ((s > 0) ? s - 1 : 0)];
          end
        end
      end
    end
  end

  rc_filter_mac #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac (
    .x     (mac_x),
    .y     (mac_y),
    .alpha (mac_alpha),
    .y_next(mac_y_next)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    st_d        = st_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    x_d         = x_q;
    act_d       = act_q;
    y_d         = y_q;
    sh_d        = sh_q;

    for (int c = 0; c < CHANNELS; c++) begin
      if (coef_we && coef_addr == 3'(c)) sh_d[c] = coef_clamped;
    end

    unique case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          for (int c = 0; c < CHANNELS; c++) x_d[c] = in[c*DATA_WIDTH +: DATA_WIDTH];
          act_d   = sh_q;
          mode_d  = mode_hp;
          ch_d    = '0;
          st_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (audio_clk_en) overrun_d = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          for (int s = 0; s < STAGES; s++) begin
            if (ch_q == 3'(c) && st_q == 2'(s)) y_d[c*STAGES + s] = mac_y_next;
          end
        end
        if (st_q == 2'(STAGES - 1)) begin
          st_d = '0;
          if (ch_q == 3'(CHANNELS - 1)) state_d = DONE;
          else ch_d = ch_q + 3'd1;
        end else begin
          st_d = st_q + 2'd1;
        end
      end
      DONE: begin
        if (audio_clk_en) overrun_d = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          out_d[c*DATA_WIDTH +: DATA_WIDTH] = mode_q[c] ? hp_sat(x_q[c], y_q[c*STAGES + STAGES - 1])
                                                        : y_q[c*STAGES + STAGES - 1];
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      st_q        <= '0;
      mode_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        x_q[c]   <= '0;
        sh_q[c]  <= ALPHA_DEFAULT;
        act_q[c] <= ALPHA_DEFAULT;
      end
      for (int i = 0; i < NY; i++) y_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      st_q        <= st_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      x_q         <= x_d;
      sh_q        <= sh_d;
      act_q       <= act_d;
      y_q         <= y_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_filter_bank.sv
// Bench for rc_filter_bank: a 1x1 instance for the numeric corner cases and a 2x2 instance
// for ordering, overrun, deferred coefficients and reset, both against an arithmetic model.
module tb_rc_filter_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_stb, a_we, a_valid, a_ovr;
  logic [15:0] a_in, a_out;
  logic [2:0]  a_addr;
  logic [16:0] a_data;
  logic [0:0]  a_mode;

  logic        b_stb, b_we, b_valid, b_ovr;
  logic [31:0] b_in, b_out;
  logic [2:0]  b_addr;
  logic [16:0] b_data;
  logic [1:0]  b_mode;

  int checks = 0;
  int errors = 0;

  rc_filter_bank #(.CHANNELS(1), .STAGES(1)) u_dut_a (
    .clk(clk), .I_RSTn(rst_n), .audio_clk_en(a_stb), .in(a_in), .coef_we(a_we),
    .coef_addr(a_addr), .coef_data(a_data), .mode_hp(a_mode), .out(a_out),
    .out_valid(a_valid), .overrun(a_ovr)
  );

  rc_filter_bank #(.CHANNELS(2), .STAGES(2)) u_dut_b (
    .clk(clk), .I_RSTn(rst_n), .audio_clk_en(b_stb), .in(b_in), .coef_we(b_we),
    .coef_addr(b_addr), .coef_data(b_data), .mode_hp(b_mode), .out(b_out),
    .out_valid(b_valid), .overrun(b_ovr)
  );

  // Reference model state: filter memories and shadow/active coefficients.
  int ya, sha, aca;
  int yb [2][2];
  int shb [2];
  int acb [2];

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int rc_step(input int y, input int x, input int a);
    longint p, q;
    p = longint'(a) * longint'(x - y);
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    return sat16(longint'(y) + q);
  endfunction

  function automatic int clamp_alpha(input int d);
    return (d > 65536) ? 65536 : d;
  endfunction

  task automatic model_reset();
    ya = 0; sha = 612; aca = 612;
    for (int c = 0; c < 2; c++) begin
      shb[c] = 612; acb[c] = 612; yb[c][0] = 0; yb[c][1] = 0;
    end
  endtask

  task automatic model_b(input int x0, input int x1, input logic [1:0] md,
                         output int e0, output int e1);
    int xs [2];
    int es [2];
    xs[0] = x0; xs[1] = x1;
    for (int c = 0; c < 2; c++) begin
      acb[c] = shb[c];
      yb[c][0] = rc_step(yb[c][0], xs[c], acb[c]);
      yb[c][1] = rc_step(yb[c][1], yb[c][0], acb[c]);
      es[c] = md[c] ? sat16(longint'(xs[c]) - longint'(yb[c][1])) : yb[c][1];
    end
    e0 = es[0]; e1 = es[1];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_a(input int addr, input int data);
    a_we = 1'b1; a_addr = 3'(addr); a_data = 17'(data);
    tick();
    a_we = 1'b0;
    if (addr < 1) sha = clamp_alpha(data);
  endtask

  task automatic write_b(input int addr, input int data);
    b_we = 1'b1; b_addr = 3'(addr); b_data = 17'(data);
    tick();
    b_we = 1'b0;
    if (addr < 2) shb[addr] = clamp_alpha(data);
  endtask

  // wmode: 0 no write, 1 write together with the strobe, 2 write during the first RUN cycle.
  task automatic sample_a(input int x, input logic md, input int wmode, input int wdata,
                          output int got, output int exp, output int lat);
    a_in = 16'(x); a_mode = md; a_stb = 1'b1;
    if (wmode == 1) begin a_we = 1'b1; a_addr = 3'd0; a_data = 17'(wdata); end
    tick();
    a_stb = 1'b0; a_we = 1'b0;
    aca = sha;
    ya = rc_step(ya, x, aca);
    exp = md ? sat16(longint'(x) - longint'(ya)) : ya;
    if (wmode != 0) sha = clamp_alpha(wdata);
    if (wmode == 2) begin a_we = 1'b1; a_addr = 3'd0; a_data = 17'(wdata); end
    lat = -1; got = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (k > 1) begin tick(); a_we = 1'b0; end
      if (a_valid) begin lat = k; got = int'($signed(a_out)); end
    end
    a_we = 1'b0;
  endtask

  task automatic sample_b(input int x0, input int x1, input logic [1:0] md, input int wmode,
                          input int waddr, input int wdata, output int g0, output int g1,
                          output int e0, output int e1, output int lat);
    b_in = {16'(x1), 16'(x0)}; b_mode = md; b_stb = 1'b1;
    if (wmode == 1) begin b_we = 1'b1; b_addr = 3'(waddr); b_data = 17'(wdata); end
    tick();
    b_stb = 1'b0; b_we = 1'b0;
    model_b(x0, x1, md, e0, e1);
    if (wmode != 0 && waddr < 2) shb[waddr] = clamp_alpha(wdata);
    if (wmode == 2) begin b_we = 1'b1; b_addr = 3'(waddr); b_data = 17'(wdata); end
    lat = -1; g0 = 0; g1 = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (k > 1) begin tick(); b_we = 1'b0; end
      if (b_valid) begin
        lat = k; g0 = int'($signed(b_out[15:0])); g1 = int'($signed(b_out[31:16]));
      end
    end
    b_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (a_out !== 16'd0 || a_valid !== 1'b0 || a_ovr !== 1'b0) begin
      errors++; $display("FAIL reset_a: out=%0d valid=%b ovr=%b, required 0/0/0", a_out, a_valid, a_ovr);
    end
    checks++; if (b_out !== 32'd0 || b_valid !== 1'b0 || b_ovr !== 1'b0) begin
      errors++; $display("FAIL reset_b: out=%h valid=%b ovr=%b, required 0/0/0", b_out, b_valid, b_ovr);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_step();
    int got, exp, lat;
    int want [3];
    want[0] = 500; want[1] = 750; want[2] = 875;
    write_a(0, 32768);
    for (int i = 0; i < 3; i++) begin
      sample_a(1000, 1'b0, 0, 0, got, exp, lat);
      checks++; if (got !== want[i] || exp !== want[i]) begin
        errors++; $display("FAIL step_%0d: got %0d, required %0d (model %0d)", i, got, want[i], exp);
      end
      checks++; if (lat !== 3) begin
        errors++; $display("FAIL step_latency_%0d: got %0d cycles, required 3", i, lat);
      end
    end
  endtask

  task automatic test_floor();
    int got, exp, lat;
    write_a(0, 65536);
    sample_a(0, 1'b0, 0, 0, got, exp, lat);
    checks++; if (got !== 0) begin
      errors++; $display("FAIL floor_zero: got %0d, required 0", got);
    end
    write_a(0, 32768);
    sample_a(-1001, 1'b0, 0, 0, got, exp, lat);
    checks++; if (got !== -501 || exp !== -501) begin
      errors++; $display("FAIL floor_neg: got %0d, required -501 (model %0d)", got, exp);
    end
  endtask

  task automatic test_hp_sat();
    int got, exp, lat;
    write_a(0, 70000);
    sample_a(-32768, 1'b1, 0, 0, got, exp, lat);
    checks++; if (got !== 0) begin
      errors++; $display("FAIL hp_preset: got %0d, required 0", got);
    end
    sample_a(-32768, 1'b1, 2, 0, got, exp, lat);
    checks++; if (got !== 0) begin
      errors++; $display("FAIL hp_deferred_zero: got %0d, required 0", got);
    end
    sample_a(32767, 1'b1, 0, 0, got, exp, lat);
    checks++; if (got !== 32767 || exp !== 32767) begin
      errors++; $display("FAIL hp_sat: got %0d, required 32767 (model %0d)", got, exp);
    end
  endtask

  task automatic test_deferred();
    int g0, g1, e0, e1, lat;
    write_b(0, 16384);
    write_b(1, 16384);
    sample_b(8000, -8000, 2'b00, 2, 0, 65536, g0, g1, e0, e1, lat);
    checks++; if (g0 !== e0 || g1 !== e1) begin
      errors++; $display("FAIL deferred_old: got %0d/%0d, required %0d/%0d", g0, g1, e0, e1);
    end
    checks++; if (lat !== 6) begin
      errors++; $display("FAIL deferred_latency: got %0d cycles, required 6", lat);
    end
    sample_b(12345, -4000, 2'b00, 0, 0, 0, g0, g1, e0, e1, lat);
    checks++; if (g0 !== 12345 || g1 !== e1) begin
      errors++; $display("FAIL deferred_new: got %0d/%0d, required 12345/%0d", g0, g1, e1);
    end
  endtask

  task automatic test_random();
    int g0, g1, e0, e1, lat, x0, x1, wm, wa, wd;
    logic [1:0] md;
    for (int i = 0; i < 12; i++) begin
      x0 = int'($urandom_range(65535)) - 32768;
      x1 = int'($urandom_range(65535)) - 32768;
      md = 2'($urandom_range(3));
      wm = int'($urandom_range(2));
      wa = int'($urandom_range(7));
      wd = int'($urandom_range(70000));
      sample_b(x0, x1, md, wm, wa, wd, g0, g1, e0, e1, lat);
      checks++; if (g0 !== e0 || g1 !== e1) begin
        errors++; $display("FAIL random_%0d: got %0d/%0d, required %0d/%0d", i, g0, g1, e0, e1);
      end
      checks++; if (lat !== 6) begin
        errors++; $display("FAIL random_latency_%0d: got %0d cycles, required 6", i, lat);
      end
    end
  endtask

  task automatic test_overrun();
    int e0, e1, nv, vcyc, g0, g1;
    checks++; if (b_ovr !== 1'b0) begin
      errors++; $display("FAIL overrun_pre: got %b, required 0", b_ovr);
    end
    b_in = {16'(-3000), 16'(20000)}; b_mode = 2'b01; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    model_b(20000, -3000, 2'b01, e0, e1);
    nv = 0; vcyc = -1; g0 = 0; g1 = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc > 1) tick();
      if (cyc == 3) begin b_in = {16'(7777), 16'(-7777)}; b_stb = 1'b1; end
      if (cyc == 4) b_stb = 1'b0;
      if (b_valid) begin
        nv++;
        if (vcyc < 0) begin
          vcyc = cyc; g0 = int'($signed(b_out[15:0])); g1 = int'($signed(b_out[31:16]));
        end
      end
    end
    checks++; if (nv !== 1 || vcyc !== 6) begin
      errors++; $display("FAIL overrun_valid: got %0d pulses first at cycle %0d, required 1 at 6", nv, vcyc);
    end
    checks++; if (b_ovr !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b, required 1", b_ovr);
    end
    checks++; if (g0 !== e0 || g1 !== e1) begin
      errors++; $display("FAIL overrun_out: got %0d/%0d, required %0d/%0d", g0, g1, e0, e1);
    end
  endtask

  task automatic test_reset_mid_run();
    int nv, g0, g1, e0, e1, lat, got, exp;
    b_in = {16'(1111), 16'(2222)}; b_mode = 2'b00; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b_out !== 32'd0 || b_valid !== 1'b0 || b_ovr !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_b: out=%h valid=%b ovr=%b, required 0/0/0", b_out, b_valid, b_ovr);
    end
    checks++; if (a_out !== 16'd0) begin
      errors++; $display("FAIL midrun_reset_a: out=%0d, required 0", a_out);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (b_valid || a_valid) nv++;
    end
    checks++; if (nv !== 0) begin
      errors++; $display("FAIL midrun_no_valid: got %0d pulses, required 0", nv);
    end
    sample_b(32767, -20000, 2'b00, 0, 0, 0, g0, g1, e0, e1, lat);
    checks++; if (g0 !== e0 || g1 !== e1) begin
      errors++; $display("FAIL post_reset_b: got %0d/%0d, required %0d/%0d", g0, g1, e0, e1);
    end
    sample_a(30000, 1'b0, 0, 0, got, exp, lat);
    checks++; if (got !== 280 || exp !== 280) begin
      errors++; $display("FAIL post_reset_alpha: got %0d, required 280 (model %0d)", got, exp);
    end
  endtask

  initial begin
    a_stb = 1'b0; a_we = 1'b0; a_in = '0; a_addr = '0; a_data = '0; a_mode = '0;
    b_stb = 1'b0; b_we = 1'b0; b_in = '0; b_addr = '0; b_data = '0; b_mode = '0;
    model_reset();
    test_reset();
    test_step();
    test_floor();
    test_hp_sat();
    test_deferred();
    test_random();
    test_overrun();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_filter_bank.md
RC_FILTER_BANK -- requirements
Module: rc_filter_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent audio channels (1..8).
REQ-002 SHALL have parameter STAGES, default 1, cascaded first-order RC sections per channel (1..4).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed sample width.
REQ-004 SHALL have parameters SAMPLE_RATE 48000, R 47000, C_35_SHIFTED 1615 (farads <<< 35), used only to compute the reset coefficient.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port I_RSTn, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port audio_clk_en, input, 1, sample strobe.
REQ-008 SHALL have port in, input, CHANNELS*DATA_WIDTH, signed samples with channel 0 in the LSBs.
REQ-009 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-010 SHALL have port coef_addr, input, 3, target channel.
REQ-011 SHALL have port coef_data, input, 17, unsigned alpha in 16-bit fraction (0..65536).
REQ-012 SHALL have port mode_hp, input, CHANNELS, per-channel high-pass select.
REQ-013 SHALL have port out, output, CHANNELS*DATA_WIDTH, signed filtered samples.
REQ-014 SHALL have port out_valid, output, 1, one-cycle pulse when a new out word is presented.
REQ-015 SHALL have port overrun, output, 1, sticky flag for a dropped strobe.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 In IDLE, audio_clk_en SHALL do three things: capture in and mode_hp, copy shadow coefficients to active, and enter RUN.
REQ-018 In RUN, the block SHALL perform one MAC step per cycle, channel-major with stage-minor ordering.
REQ-019 RUN SHALL last exactly CHANNELS*STAGES cycles and then go to DONE.
REQ-020 Each MAC step SHALL compute y_s <= y_s + ((alpha_ch * (x - y_s)) >>> 16).
REQ-021 In each MAC step, x SHALL be the captured input for stage 0 and the just-updated y of the previous stage otherwise.
REQ-022 The MAC difference SHALL be DATA_WIDTH+1 bits wide, the product signed and full-width, and the shift arithmetic (floor).
REQ-023 Each MAC result SHALL saturate to the DATA_WIDTH signed range.
REQ-024 In DONE, the block SHALL update out in a single cycle and return to IDLE.
REQ-025 In the DONE update, out_ch SHALL be y_last when mode_hp_ch=0.
REQ-026 In the DONE update, out_ch SHALL be sat(x_captured - y_last) when mode_hp_ch=1.
REQ-027 out_valid SHALL pulse high in the cycle after DONE, coincident with the new out.
REQ-028 Latency from strobe to out_valid SHALL be CHANNELS*STAGES+2 cycles.
REQ-029 audio_clk_en SHALL be ignored when it arrives in RUN or DONE, and overrun SHALL set and hold until reset.
REQ-030 A coef_we write SHALL update the shadow coefficient in any state; the active coefficient changes only at the next accepted strobe.
REQ-031 A write with coef_addr >= CHANNELS SHALL be ignored.
REQ-032 A coef_data value above 65536 SHALL be clamped to 65536.
REQ-033 When coef_we coincides with an accepted strobe, the old shadow value SHALL be copied and the new value SHALL land for the following sample.
REQ-034 alpha=0 SHALL hold the state; alpha=65536 SHALL pass x unchanged.

Reset
REQ-035 While I_RSTn=0, all of the following SHALL clear asynchronously: state to IDLE, all y_s and out to 0, out_valid to 0, overrun to 0.
REQ-036 While I_RSTn=0, captured inputs and mode SHALL clear to 0.
REQ-037 While I_RSTn=0, shadow and active alpha SHALL load ALPHA_DEFAULT = ((2^32/SAMPLE_RATE)<<16)/((R*C_35_SHIFTED>>3)+2^32/SAMPLE_RATE), which is 612 for the default parameters.
REQ-038 Reset asserted in RUN SHALL abort the sample with no out_valid.

Structure
REQ-039 Package rc_filter_pkg SHALL hold the state enum, ALPHA_FRAC=16, ALPHA_ONE=65536 and a function computing ALPHA_DEFAULT.
REQ-040 The MAC-plus-saturation datapath SHALL be one sub-module, rc_filter_mac, which is combinational and instantiated once.

Verification
REQ-041 Step test: CHANNELS=1, STAGES=1, alpha=32768, in=1000 from 0 SHALL give out 500, 750, 875 on successive out_valid.
REQ-042 Floor test: alpha=32768, in=-1001 from 0 SHALL give out=-501.
REQ-043 High-pass saturation test: mode_hp=1, alpha=0 with y preset to -32768 via prior samples at alpha=65536, then in=32767 and alpha=0 from a deferred write, SHALL give out=32767.
REQ-044 Overrun test: CHANNELS=2, STAGES=2 with a second strobe 3 cycles after the first SHALL give one out_valid at cycle 6, overrun=1 and the second sample dropped.
REQ-045 Deferred-write test: coef_we to 65536 during RUN SHALL leave the current result computed with the old alpha, and the next sample's out SHALL equal in exactly.
REQ-046 Reset test: reset asserted mid-RUN SHALL give out=0 with no out_valid, and the next sample SHALL use alpha 612.
